// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - LEGv8 instruction-fetch stage: PC, IF/ID register, stall/flush/redirect, halt detect
module fetch_stage #(
    parameter int          N          = 64,
    parameter logic [31:0] HALT_INSTR = 32'hb400001f
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall_F,
    input  logic         flush_D,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    output logic [5:0]   imem_addr,
    input  logic [31:0]  imem_q,
    output logic [N-1:0] pc_F,
    output logic [31:0]  instr_D,
    output logic [N-1:0] pc_D,
    output logic         valid_D,
    output logic         halted
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t      r_state;
    logic [N-1:0] r_pc;
    logic [31:0]  r_instr;
    logic [N-1:0] r_pc_d;
    logic         r_valid;

    state_t       w_state_nxt;
    logic [N-1:0] w_pc_nxt;
    logic [31:0]  w_instr_nxt;
    logic [N-1:0] w_pc_d_nxt;
    logic         w_valid_nxt;
    logic [N-1:0] w_pc_plus4;
    logic [N-1:0] w_target;

    assign w_pc_plus4 = r_pc + N'(4);
    assign w_target   = {branch_target[N-1:2], 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_RUN;
            r_pc    <= '0;
            r_instr <= '0;
            r_pc_d  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_pc_d  <= w_pc_d_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_pc_d_nxt  = r_pc_d;
        w_valid_nxt = r_valid;
        // Redirect wins in both states; the wrong-path fetch becomes a bubble.
        if (branch_taken) begin
            w_state_nxt = S_RUN;
            w_pc_nxt    = w_target;
            w_instr_nxt = '0;
            w_pc_d_nxt  = '0;
            w_valid_nxt = 1'b0;
        end else if (r_state == S_HALT) begin
            w_instr_nxt = '0;
            w_pc_d_nxt  = '0;
            w_valid_nxt = 1'b0;
        end else if (stall_F) begin
            if (flush_D) begin
                w_instr_nxt = '0;
                w_pc_d_nxt  = '0;
                w_valid_nxt = 1'b0;
            end
        end else if (flush_D) begin
            w_pc_nxt    = w_pc_plus4;
            w_instr_nxt = '0;
            w_pc_d_nxt  = '0;
            w_valid_nxt = 1'b0;
        end else begin
            w_instr_nxt = imem_q;
            w_pc_d_nxt  = r_pc;
            w_valid_nxt = 1'b1;
            // The halt self-loop is issued once, then fetch freezes on it.
            if (imem_q == HALT_INSTR) begin
                w_state_nxt = S_HALT;
            end else begin
                w_pc_nxt = w_pc_plus4;
            end
        end
    end

    assign imem_addr = r_pc[7:2];
    assign pc_F      = r_pc;
    assign instr_D   = r_instr;
    assign pc_D      = r_pc_d;
    assign valid_D   = r_valid;
    assign halted    = (r_state == S_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed scoreboard bench for fetch_stage
module tb_fetch_stage;

    localparam logic [31:0] HALT = 32'hb400001f;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_F;
    logic        flush_D;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic [5:0]  imem_addr;
    logic [31:0] imem_q;
    logic [63:0] pc_F;
    logic [31:0] instr_D;
    logic [63:0] pc_D;
    logic        valid_D;
    logic        halted;

    logic [31:0] rom [64];

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] pc_f;
        logic        valid;
        logic [31:0] instr;
        logic [63:0] pc_d;
        logic        halted;
        string       tag;
    } exp_t;

    exp_t sb[$];

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall_F       (stall_F),
        .flush_D       (flush_D),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_q        (imem_q),
        .pc_F          (pc_F),
        .instr_D       (instr_D),
        .pc_D          (pc_D),
        .valid_D       (valid_D),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    always_comb imem_q = rom[imem_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input exp_t e);
        logic [63:0] w_addr;
        w_addr = {58'd0, e.pc_f[7:2]};
        chk({e.tag, ".pc_F"},      pc_F,                e.pc_f);
        chk({e.tag, ".imem_addr"}, {58'd0, imem_addr},  w_addr);
        chk({e.tag, ".valid_D"},   {63'd0, valid_D},    {63'd0, e.valid});
        chk({e.tag, ".instr_D"},   {32'd0, instr_D},    {32'd0, e.instr});
        chk({e.tag, ".pc_D"},      pc_D,                e.pc_d);
        chk({e.tag, ".halted"},    {63'd0, halted},     {63'd0, e.halted});
    endtask

    // Called with clk low; drives inputs, clocks once, checks, returns at the next falling edge.
    task automatic step(input string tag, input logic s, input logic f, input logic b,
                        input logic [63:0] tgt, input logic [63:0] epc, input logic ev,
                        input logic [31:0] ei, input logic [63:0] epd, input logic eh);
        exp_t e;
        stall_F       = s;
        flush_D       = f;
        branch_taken  = b;
        branch_target = tgt;
        e = '{pc_f: epc, valid: ev, instr: ei, pc_d: epd, halted: eh, tag: tag};
        sb.push_back(e);
        @(posedge clk);
        #1;
        chk_all(sb.pop_front());
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'h91000000 + i;
        rom[0] = 32'h8b1e03c5;
        rom[1] = 32'h8b0400a5;
        rom[9] = HALT;
        stall_F = 0; flush_D = 0; branch_taken = 0; branch_target = '0;
        reset = 1'b1;
        #1;
        chk_all('{pc_f: 64'd0, valid: 1'b0, instr: 32'd0, pc_d: 64'd0, halted: 1'b0, tag: "reset"});
        @(negedge clk);
        reset = 1'b0;

        step("run0",   0, 0, 0, 0, 64'h04, 1, 32'h8b1e03c5, 64'h00, 0);
        step("run1",   0, 0, 0, 0, 64'h08, 1, 32'h8b0400a5, 64'h04, 0);
        step("stall0", 1, 0, 0, 0, 64'h08, 1, 32'h8b0400a5, 64'h04, 0);
        step("stall1", 1, 0, 0, 0, 64'h08, 1, 32'h8b0400a5, 64'h04, 0);
        step("rel0",   0, 0, 0, 0, 64'h0C, 1, rom[2],       64'h08, 0);
        step("rel1",   0, 0, 0, 0, 64'h10, 1, rom[3],       64'h0C, 0);
        step("brstl",  1, 0, 1, 64'h23, 64'h20, 0, 32'd0,   64'h00, 0);
        step("brtgt",  0, 0, 0, 0, 64'h24, 1, rom[8],       64'h20, 0);
        step("halt",   0, 0, 0, 0, 64'h24, 1, HALT,         64'h24, 1);
        step("hold0",  0, 0, 0, 0, 64'h24, 0, 32'd0,        64'h00, 1);
        step("hold1",  1, 1, 0, 0, 64'h24, 0, 32'd0,        64'h00, 1);
        step("unhalt", 0, 0, 1, 64'h0, 64'h00, 0, 32'd0,    64'h00, 0);
        rom[9] = 32'h91000009;

        for (int k = 1; k <= 12; k++)
            step("free", 0, 0, 0, 0, 64'(4 * k), 1, rom[k-1], 64'(4 * (k - 1)), 0);

        step("flush",  0, 1, 0, 0, 64'h34, 0, 32'd0, 64'h00, 0);
        step("flstl",  1, 1, 0, 0, 64'h34, 0, 32'd0, 64'h00, 0);
        step("run13",  0, 0, 0, 0, 64'h38, 1, rom[13], 64'h34, 0);
        step("run14",  0, 0, 0, 0, 64'h3C, 1, rom[14], 64'h38, 0);
        step("run15",  0, 0, 0, 0, 64'h40, 1, rom[15], 64'h3C, 0);

        reset = 1'b1;
        #1;
        chk_all('{pc_f: 64'd0, valid: 1'b0, instr: 32'd0, pc_d: 64'd0, halted: 1'b0, tag: "midrst"});
        #1;
        reset = 1'b0;
        step("post0",  0, 0, 0, 0, 64'h04, 1, rom[0], 64'h00, 0);
        step("post1",  0, 0, 0, 0, 64'h08, 1, rom[1], 64'h04, 0);
        step("post2",  0, 0, 0, 0, 64'h0C, 1, rom[2], 64'h08, 0);

        step("brwrap", 0, 0, 1, 64'hFF, 64'hFC, 0, 32'd0, 64'h00, 0);
        step("addrwr", 0, 0, 0, 0, 64'h100, 1, rom[63], 64'hFC, 0);
        step("brtop",  0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFC, 0, 32'd0, 64'h00, 0);
        step("pcwrap", 0, 0, 0, 0, 64'h0, 1, rom[63], 64'hFFFF_FFFF_FFFF_FFFC, 0);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard leftover=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
